hdmi_period_sequencer: RTL and testbench
========================================

// Module: hdmi_period_sequencer
// PURPOSE
//  Sequences HDMI 1.4a video periods for the three TMDS encoder channels: control period, video
//  preamble (8 chars), leading video guard band (2 chars), video data. Consumes raw timing
//  (DE/HSYNC/VSYNC/pixel) from the video timing generator, delays it by a fixed look-ahead, and
//  drives each encoder's VDE/CTRL plus a GUARD flag that the output mux uses to substitute guard codes.
// PARAMETERS
//  LOOKAHEAD  10  output delay in PIXCLK cycles; must equal PRE_LEN + GB_LEN
//  PRE_LEN    8   preamble length, characters
//  GB_LEN     2   guard band length, characters
//  MIN_CTRL   12  minimum control-period length, in input chars, needed before preamble+guard insertion
//  DVI_MODE   0   1 = no preamble/guard ever inserted (plain DVI); CTRL of ch1/ch2 held 2'b00
// PORTS
//  PIXCLK      in   1   pixel clock; single clock domain
//  RESET       in   1   synchronous, active-high reset
//  DE_IN       in   1   video data enable from timing generator
//  HSYNC_IN    in   1   horizontal sync
//  VSYNC_IN    in   1   vertical sync
//  PIX_IN      in   24  {R,G,B} pixel, 8 bits each
//  PIX_OUT     out  24  PIX_IN delayed LOOKAHEAD cycles
//  VDE_OUT     out  1   VDE to all three encoders (delayed DE)
//  CH0_CTRL    out  2   {VSYNC,HSYNC} delayed; ch0 CTRL
//  CH1_CTRL    out  2   {CTL1,CTL0}
//  CH2_CTRL    out  2   {CTL3,CTL2}
//  GUARD       out  1   1 = output char is a video guard band char
//  SHORT_CTRL  out  1   one-cycle pulse: video start without preamble (control period < MIN_CTRL)
// BEHAVIOUR
//  - Reset: all outputs 0; delay line cleared (DE/HS/VS/pixel = 0); FSM = CTRL; ctrl_cnt = 0.
//  - Latency: PIX_OUT, VDE_OUT, CH0_CTRL = inputs delayed exactly LOOKAHEAD cycles, all registered.
//  - FSM states: CTRL, PREAMBLE, GUARD, VIDEO. Counter phase_cnt 4 bits; ctrl_cnt saturates at MIN_CTRL.
//  - ctrl_cnt counts input cycles with DE_IN=0, cleared on DE_IN=1.
//  - CTRL -> PREAMBLE on DE_IN rising (DE_IN=1, previous 0) with ctrl_cnt >= MIN_CTRL and DVI_MODE=0.
//    Else rising edge leaves FSM in CTRL; delayed DE yields plain VIDEO; SHORT_CTRL pulses on
//    the output cycle VDE_OUT first rises.
//  - Timing: if delayed DE first rises on output cycle n, PREAMBLE covers output cycles n-10..n-3,
//    GUARD covers n-2..n-1, VIDEO starts at n. PREAMBLE -> GUARD after PRE_LEN chars,
//    GUARD -> VIDEO after GB_LEN chars, VIDEO -> CTRL on first output cycle with VDE_OUT=0.
//  - PREAMBLE outputs: CH1_CTRL=2'b01 (CTL0=1), CH2_CTRL=2'b00, VDE_OUT=0, GUARD=0.
//  - GUARD outputs: GUARD=1, VDE_OUT=0, CH1/CH2_CTRL=2'b00. Mux codes ch0/ch2 10'b1011001100, ch1 10'b0100110011.
//  - CTRL/VIDEO outputs: CH1/CH2_CTRL=2'b00, GUARD=0. CH0_CTRL always tracks delayed sync, incl. preamble/guard.
//  - Invariant: GUARD and VDE_OUT never 1 together; preamble never nonzero while VDE_OUT=1.
//  - DE_IN pulse shorter than LOOKAHEAD: full preamble+guard still emitted; video length = pulse length.
//  - Second DE rise during PREAMBLE/GUARD/VIDEO: impossible to qualify (ctrl_cnt < MIN_CTRL); ignored.
//  - RESET mid-period: next cycle all outputs 0, FSM=CTRL; in-flight pixels discarded, not replayed.
//  - Trailing guard bands and data islands are out of scope; no guard after video.
// STRUCTURE
//  - Package hdmi_pkg: FSM state enum; GB_CODE_CH0/1/2 10-bit constants; PREAMBLE_VIDEO = 4'b0001
//    ({CTL3..CTL0}); default PRE_LEN/GB_LEN. Shared with the encoder output mux.
//  - Sub-module hdmi_timing_delay: parameterized-depth register shift line for {DE,VS,HS,PIX},
//    synchronous clear on RESET. Sequencer = edge detect + ctrl_cnt + FSM + output regs.
// TESTING
//  1 RESET=1 3 cycles, random inputs -> all outputs 0; after release, 10 cycles of 0s from delay line.
//  2 DE_IN low 100 cycles then high 20: delayed DE rise at n; CH1_CTRL=01 on n-10..n-3,
//    GUARD=1 on n-2,n-1, VDE_OUT=1 on n..n+19, PIX_OUT = PIX_IN exactly 10 cycles later.
//  3 DE low gap of 5 between two video lines -> second line: no preamble/guard, SHORT_CTRL one pulse at its VDE rise.
//  4 DE_IN high 3 cycles after long gap -> 8 preamble, 2 guard, 3 video chars, back to CTRL with CH1_CTRL=00.
//  5 DVI_MODE=1, same stimulus as 2 -> GUARD always 0, CH1/CH2_CTRL always 00, VDE_OUT delayed 10.
//  6 RESET asserted during GUARD -> next cycle GUARD=0, VDE_OUT=0, FSM CTRL; VSYNC/HSYNC toggling preserved in CH0_CTRL after 10 cycles.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared HDMI video-period definitions: sequencer state encoding, guard-band
// characters and video preamble control pattern used by the encoder output mux.
package hdmi_pkg;

    typedef enum logic [1:0] {
        ST_CTRL,
        ST_PREAMBLE,
        ST_GUARD,
        ST_VIDEO
    } period_state_t;

    localparam logic [9:0] GB_CODE_CH0 = 10'b1011001100;
    localparam logic [9:0] GB_CODE_CH1 = 10'b0100110011;
    localparam logic [9:0] GB_CODE_CH2 = 10'b1011001100;

    // {CTL3, CTL2, CTL1, CTL0} during a video preamble
    localparam logic [3:0] PREAMBLE_VIDEO = 4'b0001;

    localparam int unsigned DEF_PRE_LEN = 8;
    localparam int unsigned DEF_GB_LEN  = 2;

    typedef struct packed {
        logic        de;
        logic        vs;
        logic        hs;
        logic [23:0] pix;
    } timing_t;

endpackage

// File: rtl/hdmi_period_sequencer_if.sv
// Timing-in / encoder-control-out bundle between the timing generator,
// the period sequencer and the TMDS encoders.
interface hdmi_period_sequencer_if;

    logic        DE_IN;
    logic        HSYNC_IN;
    logic        VSYNC_IN;
    logic [23:0] PIX_IN;
    logic [23:0] PIX_OUT;
    logic        VDE_OUT;
    logic [1:0]  CH0_CTRL;
    logic [1:0]  CH1_CTRL;
    logic [1:0]  CH2_CTRL;
    logic        GUARD;
    logic        SHORT_CTRL;

    modport master (
        output DE_IN, HSYNC_IN, VSYNC_IN, PIX_IN,
        input  PIX_OUT, VDE_OUT, CH0_CTRL, CH1_CTRL, CH2_CTRL, GUARD, SHORT_CTRL
    );

    modport slave (
        input  DE_IN, HSYNC_IN, VSYNC_IN, PIX_IN,
        output PIX_OUT, VDE_OUT, CH0_CTRL, CH1_CTRL, CH2_CTRL, GUARD, SHORT_CTRL
    );

endinterface

// File: rtl/hdmi_timing_delay.sv
// Fixed-depth shift line for {DE, VS, HS, pixel}; cleared synchronously so
// in-flight characters are dropped on reset.
module hdmi_timing_delay
    import hdmi_pkg::*;
#(
    parameter int unsigned DEPTH = 10
) (
    input  logic    PIXCLK,
    input  logic    RESET,
    input  timing_t din,
    output timing_t dout
);

    timing_t line [DEPTH];

    always_ff @(posedge PIXCLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign dout = line[DEPTH-1];

endmodule

// File: rtl/hdmi_period_sequencer.sv
// HDMI video period sequencer: delays raw timing by LOOKAHEAD characters and
// inserts preamble + leading guard band ahead of each qualified video period.
module hdmi_period_sequencer
    import hdmi_pkg::*;
#(
    parameter int unsigned LOOKAHEAD = 10,
    parameter int unsigned PRE_LEN   = DEF_PRE_LEN,
    parameter int unsigned GB_LEN    = DEF_GB_LEN,
    parameter int unsigned MIN_CTRL  = 12,
    parameter bit          DVI_MODE  = 1'b0
) (
    input  logic                    PIXCLK,
    input  logic                    RESET,
    hdmi_period_sequencer_if.slave  bus
);

    localparam int unsigned CCW = $clog2(MIN_CTRL + 1);

    timing_t tin;
    timing_t tout;

    assign tin = '{de: bus.DE_IN, vs: bus.VSYNC_IN, hs: bus.HSYNC_IN, pix: bus.PIX_IN};

    hdmi_timing_delay #(.DEPTH(LOOKAHEAD)) u_delay (
        .PIXCLK (PIXCLK),
        .RESET  (RESET),
        .din    (tin),
        .dout   (tout)
    );

    logic           de_prev;
    logic [CCW-1:0] ctrl_cnt;
    logic           vde_d1;
    period_state_t  state, state_nxt;
    logic [3:0]     phase_cnt, phase_nxt;
    logic           de_rise;
    logic           qualify;
    logic           pre_now;
    logic [3:0]     ctl;

    assign de_rise = bus.DE_IN & ~de_prev;
    assign qualify = de_rise && (ctrl_cnt >= CCW'(MIN_CTRL)) && !DVI_MODE;

    always_ff @(posedge PIXCLK) begin
        if (RESET) begin
            de_prev   <= 1'b0;
            ctrl_cnt  <= '0;
            vde_d1    <= 1'b0;
            state     <= ST_CTRL;
            phase_cnt <= '0;
        end else begin
            de_prev <= bus.DE_IN;
            if (bus.DE_IN) begin
                ctrl_cnt <= '0;
            end else if (ctrl_cnt < CCW'(MIN_CTRL)) begin
                ctrl_cnt <= ctrl_cnt + CCW'(1);
            end
            vde_d1    <= tout.de;
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
        end
    end

    // The first preamble character coincides with the input DE rise, which is
    // exactly LOOKAHEAD characters ahead of the delayed VDE; it is emitted from
    // the CTRL state directly, and PREAMBLE then counts the remaining chars.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        pre_now   = 1'b0;
        case (state)
            ST_CTRL: begin
                if (qualify) begin
                    state_nxt = ST_PREAMBLE;
                    phase_nxt = 4'd1;
                    pre_now   = 1'b1;
                end else if (tout.de) begin
                    state_nxt = ST_VIDEO;
                end
            end
            ST_PREAMBLE: begin
                if (phase_cnt == 4'(PRE_LEN - 1)) begin
                    state_nxt = ST_GUARD;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + 4'd1;
                end
            end
            ST_GUARD: begin
                if (phase_cnt == 4'(GB_LEN - 1)) begin
                    state_nxt = ST_VIDEO;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + 4'd1;
                end
            end
            ST_VIDEO: begin
                if (!tout.de) begin
                    state_nxt = ST_CTRL;
                end
            end
            default: state_nxt = ST_CTRL;
        endcase
        ctl = ((state == ST_PREAMBLE) || pre_now) ? PREAMBLE_VIDEO : '0;
    end

    assign bus.PIX_OUT    = tout.pix;
    assign bus.VDE_OUT    = tout.de;
    assign bus.CH0_CTRL   = {tout.vs, tout.hs};
    assign bus.CH1_CTRL   = ctl[1:0];
    assign bus.CH2_CTRL   = ctl[3:2];
    assign bus.GUARD      = (state == ST_GUARD);
    assign bus.SHORT_CTRL = tout.de & ~vde_d1 & (state == ST_CTRL);

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Bench for hdmi_period_sequencer: HDMI and DVI instances share one stimulus
// stream; every cycle is compared against a history-based period model.
module tb_hdmi_period_sequencer;

    localparam int MAXC = 8000;
    localparam int LA   = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        de, hs, vs;
    logic [23:0] pix;

    always #5 clk = ~clk;

    hdmi_period_sequencer_if bus_h ();
    hdmi_period_sequencer_if bus_d ();

    assign bus_h.DE_IN    = de;
    assign bus_h.HSYNC_IN = hs;
    assign bus_h.VSYNC_IN = vs;
    assign bus_h.PIX_IN   = pix;
    assign bus_d.DE_IN    = de;
    assign bus_d.HSYNC_IN = hs;
    assign bus_d.VSYNC_IN = vs;
    assign bus_d.PIX_IN   = pix;

    hdmi_period_sequencer #(
        .LOOKAHEAD(10), .PRE_LEN(8), .GB_LEN(2), .MIN_CTRL(12), .DVI_MODE(1'b0)
    ) u_hdmi (
        .PIXCLK (clk),
        .RESET  (rst),
        .bus    (bus_h)
    );

    hdmi_period_sequencer #(
        .LOOKAHEAD(10), .PRE_LEN(8), .GB_LEN(2), .MIN_CTRL(12), .DVI_MODE(1'b1)
    ) u_dvi (
        .PIXCLK (clk),
        .RESET  (rst),
        .bus    (bus_d)
    );

    bit          rst_a [MAXC];
    bit          de_a  [MAXC];
    bit          hs_a  [MAXC];
    bit          vs_a  [MAXC];
    logic [23:0] pix_a [MAXC];
    int          cyc;

    int checks   = 0;
    int failures = 0;

    int cnt_pre, cnt_gb, cnt_vde, cnt_short, cnt_dvi_gb, cnt_dvi_ctl, cnt_dvi_vde, cnt_nz;
    logic obs_guard, obs_vde;
    logic [1:0] obs_ch1;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // History before cycle 0 counts as reset.
    function automatic bit anyrst(int lo, int hi);
        if (lo < 0) return 1'b1;
        for (int j = lo; j <= hi; j++) if (rst_a[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit del_ok(int t);
        return !anyrst(t - LA, t - 1);
    endfunction

    // Rising DE at input cycle k preceded by at least 12 idle input cycles.
    function automatic bit qual(int k, bit dvi);
        bit prev;
        int z;
        if (k < 0 || dvi || !de_a[k]) return 1'b0;
        prev = (k > 0 && !rst_a[k-1]) ? de_a[k-1] : 1'b0;
        if (prev) return 1'b0;
        z = 0;
        for (int j = k - 1; j >= 0 && z < 12; j--) begin
            if (rst_a[j] || de_a[j]) break;
            z++;
        end
        return z >= 12;
    endfunction

    function automatic bit pre_m(int t, bit dvi);
        for (int k = t - 7; k <= t; k++) if (qual(k, dvi) && !anyrst(k, t - 1)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit guard_m(int t, bit dvi);
        for (int k = t - 9; k <= t - 8; k++) if (qual(k, dvi) && !anyrst(k, t - 1)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit vde_m(int t);
        if (!del_ok(t)) return 1'b0;
        return de_a[t - LA];
    endfunction

    function automatic bit short_m(int t, bit dvi);
        return vde_m(t) && !vde_m(t - 1) && !(qual(t - LA, dvi) && del_ok(t));
    endfunction

    task automatic check_cycle(input int t);
        logic [23:0] e_pix;
        logic [1:0]  e_ch0;
        e_pix = '0;
        e_ch0 = '0;
        if (del_ok(t)) begin
            e_pix = pix_a[t - LA];
            e_ch0 = {vs_a[t - LA], hs_a[t - LA]};
        end
        chk("pix",        bus_h.PIX_OUT,    e_pix);
        chk("vde",        bus_h.VDE_OUT,    24'(vde_m(t)));
        chk("ch0",        bus_h.CH0_CTRL,   24'(e_ch0));
        chk("ch1",        bus_h.CH1_CTRL,   pre_m(t, 1'b0) ? 24'd1 : 24'd0);
        chk("ch2",        bus_h.CH2_CTRL,   24'd0);
        chk("guard",      bus_h.GUARD,      24'(guard_m(t, 1'b0)));
        chk("short",      bus_h.SHORT_CTRL, 24'(short_m(t, 1'b0)));
        chk("inv_gb_vde", bus_h.GUARD & bus_h.VDE_OUT, 24'd0);
        chk("inv_pre_vde", (bus_h.CH1_CTRL != 2'b00) & bus_h.VDE_OUT, 24'd0);
        chk("dvi_pix",    bus_d.PIX_OUT,    e_pix);
        chk("dvi_vde",    bus_d.VDE_OUT,    24'(vde_m(t)));
        chk("dvi_ch0",    bus_d.CH0_CTRL,   24'(e_ch0));
        chk("dvi_ch1",    bus_d.CH1_CTRL,   24'd0);
        chk("dvi_ch2",    bus_d.CH2_CTRL,   24'd0);
        chk("dvi_guard",  bus_d.GUARD,      24'd0);
        chk("dvi_short",  bus_d.SHORT_CTRL, 24'(short_m(t, 1'b1)));
    endtask

    task automatic clear_counts();
        cnt_pre = 0; cnt_gb = 0; cnt_vde = 0; cnt_short = 0;
        cnt_dvi_gb = 0; cnt_dvi_ctl = 0; cnt_dvi_vde = 0; cnt_nz = 0;
    endtask

    task automatic cycle(input bit r, input bit d);
        rst = r;
        de  = d;
        hs  = 1'($urandom_range(0, 1));
        vs  = 1'($urandom_range(0, 1));
        pix = 24'($urandom);
        rst_a[cyc] = r;
        de_a[cyc]  = d;
        hs_a[cyc]  = hs;
        vs_a[cyc]  = vs;
        pix_a[cyc] = pix;
        @(negedge clk);
        check_cycle(cyc);
        obs_guard = bus_h.GUARD;
        obs_vde   = bus_h.VDE_OUT;
        obs_ch1   = bus_h.CH1_CTRL;
        if (bus_h.CH1_CTRL == 2'b01) cnt_pre++;
        if (bus_h.GUARD) cnt_gb++;
        if (bus_h.VDE_OUT) cnt_vde++;
        if (bus_h.SHORT_CTRL) cnt_short++;
        if (bus_d.GUARD) cnt_dvi_gb++;
        if (bus_d.CH1_CTRL != 2'b00 || bus_d.CH2_CTRL != 2'b00) cnt_dvi_ctl++;
        if (bus_d.VDE_OUT) cnt_dvi_vde++;
        if (bus_h.PIX_OUT != '0 || bus_h.VDE_OUT || bus_h.CH0_CTRL != '0 || bus_h.CH1_CTRL != '0
            || bus_h.GUARD || bus_h.SHORT_CTRL) cnt_nz++;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget got=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic run(input bit r, input bit d, input int n);
        for (int i = 0; i < n; i++) cycle(r, d);
    endtask

    initial begin
        rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; pix = '0;
        cyc = 0;
        clear_counts();
        @(posedge clk);
        #1;

        // Reset with random DE, then the delay line must drain zeros.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1 & 1'($urandom_range(0, 1)));
        clear_counts();
        run(1'b0, 1'b0, 1);
        chk("rst_release_nz", 24'(cnt_nz), 24'd0);
        run(1'b0, 1'b0, 9);

        // Long control period then a 20-char line.
        run(1'b0, 1'b0, 100);
        clear_counts();
        run(1'b0, 1'b1, 20);
        run(1'b0, 1'b0, 30);
        chk("t2_pre_len",    24'(cnt_pre),     24'd8);
        chk("t2_gb_len",     24'(cnt_gb),      24'd2);
        chk("t2_vde_len",    24'(cnt_vde),     24'd20);
        chk("t2_short",      24'(cnt_short),   24'd0);
        chk("t5_dvi_gb",     24'(cnt_dvi_gb),  24'd0);
        chk("t5_dvi_ctl",    24'(cnt_dvi_ctl), 24'd0);
        chk("t5_dvi_vde",    24'(cnt_dvi_vde), 24'd20);

        // Two lines separated by a 5-char gap.
        clear_counts();
        run(1'b0, 1'b1, 20);
        run(1'b0, 1'b0, 5);
        run(1'b0, 1'b1, 20);
        run(1'b0, 1'b0, 30);
        chk("t3_pre_len",    24'(cnt_pre),   24'd8);
        chk("t3_gb_len",     24'(cnt_gb),    24'd2);
        chk("t3_vde_len",    24'(cnt_vde),   24'd40);
        chk("t3_short",      24'(cnt_short), 24'd1);

        // DE pulse shorter than the look-ahead.
        clear_counts();
        run(1'b0, 1'b1, 3);
        run(1'b0, 1'b0, 20);
        chk("t4_pre_len",    24'(cnt_pre),   24'd8);
        chk("t4_gb_len",     24'(cnt_gb),    24'd2);
        chk("t4_vde_len",    24'(cnt_vde),   24'd3);
        chk("t4_ch1_end",    24'(obs_ch1),   24'd0);

        // Reset while the guard band is on the output.
        run(1'b0, 1'b1, 8);
        cycle(1'b1, 1'b1);
        chk("t6_guard_pre_rst", 24'(obs_guard), 24'd1);
        cycle(1'b0, 1'b1);
        chk("t6_guard_post_rst", 24'(obs_guard), 24'd0);
        chk("t6_vde_post_rst",   24'(obs_vde),   24'd0);
        run(1'b0, 1'b1, 5);
        run(1'b0, 1'b0, 30);

        // Random line/gap lengths with occasional reset.
        for (int l = 0; l < 50; l++) begin
            int gap, len;
            gap = $urandom_range(1, 30);
            len = $urandom_range(1, 25);
            for (int i = 0; i < gap; i++) cycle(1'($urandom_range(0, 149) == 0), 1'b0);
            for (int i = 0; i < len; i++) cycle(1'($urandom_range(0, 149) == 0), 1'b1);
        end
        run(1'b0, 1'b0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
